// File: rtl/simd_sequencer.sv
// -----------------------------------------------------------------------------
// simd_sequencer
//   Start/done controlled fetch/execute sequencer for the SIMD core. Walks
//   instruction memory from start_addr to last_addr and strobes exec_en once
//   per datapath instruction. It handles LOOP (single-level repeat) and HALT
//   itself; these never reach the datapath.
//
// Ports
//   clk, rstn       : clock, synchronous active-low reset
//   start           : one-cycle run request (sampled in IDLE only)
//   start_addr      : first instruction address (captured with start)
//   last_addr       : final instruction address (captured with start)
//   hold            : stall; freezes the sequencer in FETCH/EXEC
//   instruction     : memory read data for the pc of the previous cycle
//   pc              : instruction memory read address
//   exec_en         : commit the current instruction this cycle
//   busy            : program in progress (FETCH/EXEC)
//   done            : one-cycle pulse at program end
//   halted          : last program ended on HALT rather than last_addr
// -----------------------------------------------------------------------------
module simd_sequencer #(
  parameter int INS_ADDR_WIDTH = 10,
  parameter int ADDR_WIDTH     = 10,
  parameter int OPCODE_WIDTH   = 3
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic [INS_ADDR_WIDTH-1:0]           start_addr,
  input  logic [INS_ADDR_WIDTH-1:0]           last_addr,
  input  logic                                hold,
  input  logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0] instruction,
  output logic [INS_ADDR_WIDTH-1:0]           pc,
  output logic                                exec_en,
  output logic                                busy,
  output logic                                done,
  output logic                                halted
);

  localparam int INS_W = OPCODE_WIDTH + 3 * ADDR_WIDTH;

  // The two highest opcodes are control ops; everything below is datapath.
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = '1;
  localparam logic [OPCODE_WIDTH-1:0] OP_LOOP = OP_HALT - 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [INS_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INS_ADDR_WIDTH-1:0] last_q, last_d;
  logic [ADDR_WIDTH-1:0]     loop_cnt_q, loop_cnt_d;
  logic                      loop_active_q, loop_active_d;
  logic                      halted_q, halted_d;

  logic [OPCODE_WIDTH-1:0]   opcode;
  logic [ADDR_WIDTH-1:0]     a_field;
  logic [ADDR_WIDTH-1:0]     b_field;
  logic [ADDR_WIDTH-1:0]     r_field;
  logic [INS_ADDR_WIDTH-1:0] target;
  logic                      is_dp;
  logic                      take_jump;
  logic                      unused_b_field;

  assign opcode  = instruction[INS_W-1 -: OPCODE_WIDTH];
  assign a_field = instruction[2*ADDR_WIDTH +: ADDR_WIDTH];
  assign b_field = instruction[ADDR_WIDTH +: ADDR_WIDTH];
  assign r_field = instruction[ADDR_WIDTH-1:0];
  assign target  = r_field[INS_ADDR_WIDTH-1:0];
  assign is_dp   = (opcode < OP_LOOP);

  // The middle operand field belongs to the decoder only.
  assign unused_b_field = ^b_field;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    last_d        = last_q;
    loop_cnt_d    = loop_cnt_q;
    loop_active_d = loop_active_q;
    halted_d      = halted_q;
    take_jump     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d          = start_addr;
          last_d        = last_addr;
          loop_cnt_d    = '0;
          loop_active_d = 1'b0;
          halted_d      = 1'b0;
          state_d       = S_FETCH;
        end
      end

      S_FETCH: begin
        if (!hold) state_d = S_EXEC;
      end

      S_EXEC: begin
        if (!hold) begin
          if (opcode == OP_HALT) begin
            halted_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            if (opcode == OP_LOOP) begin
              // One shared counter: the first LOOP arms it with a_field-1
              // remaining repeats, later passes count it down to zero.
              if (!loop_active_q && (a_field != '0)) begin
                loop_cnt_d    = a_field - 1'b1;
                loop_active_d = 1'b1;
                take_jump     = 1'b1;
              end else if (loop_active_q && (loop_cnt_q != '0)) begin
                loop_cnt_d = loop_cnt_q - 1'b1;
                take_jump  = 1'b1;
              end else begin
                loop_active_d = 1'b0;
              end
            end

            if (take_jump) begin
              pc_d    = target;
              state_d = S_FETCH;
            end else if (pc_q == last_q) begin
              state_d = S_DONE;
            end else begin
              pc_d    = pc_q + 1'b1;   // wraps modulo 2^INS_ADDR_WIDTH
              state_d = S_FETCH;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      last_q        <= '0;
      loop_cnt_q    <= '0;
      loop_active_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      last_q        <= last_d;
      loop_cnt_q    <= loop_cnt_d;
      loop_active_q <= loop_active_d;
      halted_q      <= halted_d;
    end
  end

  // Moore outputs from the state register; exec_en is additionally gated
  // by the stall and by the opcode so control ops never reach the datapath.
  assign pc      = pc_q;
  assign busy    = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign done    = (state_q == S_DONE);
  assign halted  = halted_q;
  assign exec_en = (state_q == S_EXEC) && !hold && is_dp;

endmodule

// File: tb/tb_simd_sequencer.sv
module tb_simd_sequencer;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [9:0]  start_addr;
  logic [9:0]  last_addr;
  logic        hold;
  logic [32:0] instruction;
  logic [9:0]  pc;
  logic        exec_en;
  logic        busy;
  logic        done;
  logic        halted;

  simd_sequencer #(
    .INS_ADDR_WIDTH(10),
    .ADDR_WIDTH    (10),
    .OPCODE_WIDTH  (3)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .start_addr (start_addr),
    .last_addr  (last_addr),
    .hold       (hold),
    .instruction(instruction),
    .pc         (pc),
    .exec_en    (exec_en),
    .busy       (busy),
    .done       (done),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: synchronous read, one cycle latency.
  logic [32:0] mem [1024];
  always @(posedge clk) instruction <= mem[pc];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ins(input int op, input int a, input int r);
    logic [32:0] w;
    w = {op[2:0], a[9:0], 10'd0, r[9:0]};
    return w;
  endfunction

  // ---------------- reference model: program interpreter ----------------
  int exp_pc_q[$];
  int exp_cyc_q[$];
  int m_steps;
  int m_final;
  bit m_halt;

  function automatic void model(input int sa, input int la);
    int p, cnt, steps, op, a, t;
    bit act;
    logic [32:0] w;
    p = sa; cnt = 0; steps = 0; act = 0; m_halt = 0;
    exp_pc_q.delete();
    exp_cyc_q.delete();
    for (int guard = 0; guard < 4000; guard++) begin
      w = mem[p];
      op = int'(w[32:30]);
      a  = int'(w[29:20]);
      t  = int'(w[9:0]);
      steps++;
      if (op == 7) begin
        m_halt = 1;
        break;
      end
      if (op == 6) begin
        if (!act && a != 0) begin
          act = 1; cnt = a - 1; p = t;
          continue;
        end else if (act && cnt != 0) begin
          cnt--; p = t;
          continue;
        end else begin
          act = 0;
        end
      end else begin
        exp_pc_q.push_back(p);
        exp_cyc_q.push_back(2 * steps);  // k-th instruction executes in cycle 2k
      end
      if (p == la) break;
      p = (p + 1) % 1024;
    end
    m_steps = steps;
    m_final = p;
  endfunction

  // ---------------- run one program on the DUT ----------------
  int got_pc_q[$];
  int got_cyc_q[$];
  int r_ncyc, r_nhold;
  bit r_done_seen;
  logic r_halted;
  logic [9:0] r_pc;

  task automatic run(input int sa, input int la, input int hold_pct,
                     input int hs, input int hl);
    int cyc;
    got_pc_q.delete();
    got_cyc_q.delete();
    r_nhold = 0;
    r_done_seen = 0;
    start = 1'b1; start_addr = sa[9:0]; last_addr = la[9:0]; hold = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 5000) begin
      hold = ((cyc >= hs) && (cyc < hs + hl)) || ($urandom_range(0, 99) < hold_pct);
      @(negedge clk);
      if (done) begin
        r_done_seen = 1;
        break;
      end
      if (hold) r_nhold++;
      if (exec_en) begin
        got_pc_q.push_back(int'(pc));
        got_cyc_q.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
    end
    r_ncyc = cyc;
    r_halted = halted;
    r_pc = pc;
    chk("done_seen", {63'd0, r_done_seen}, 64'd1);
    hold = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_pulse_width", {63'd0, done}, 64'd0);
    chk("idle_after_done", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic verify(input string tag, input int sa, input int la);
    model(sa, la);
    chk({tag, "_cycles"}, 64'(r_ncyc), 64'(2 * m_steps + 1 + r_nhold));
    chk({tag, "_halted"}, {63'd0, r_halted}, {63'd0, m_halt});
    chk({tag, "_final_pc"}, {54'd0, r_pc}, 64'(m_final));
    chk({tag, "_exec_count"}, 64'(got_pc_q.size()), 64'(exp_pc_q.size()));
    for (int i = 0; i < exp_pc_q.size() && i < got_pc_q.size(); i++) begin
      chk({tag, "_exec_pc"}, 64'(got_pc_q[i]), 64'(exp_pc_q[i]));
      if (r_nhold == 0)
        chk({tag, "_exec_cycle"}, 64'(got_cyc_q[i]), 64'(exp_cyc_q[i]));
    end
  endtask

  initial begin
    int dn, bz, sa, len, la, lpos, op;
    rstn = 1'b0; start = 1'b0; hold = 1'b0; start_addr = '0; last_addr = '0;
    for (int i = 0; i < 1024; i++) mem[i] = ins(0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_pc", {54'd0, pc}, 64'd0);
    chk("reset_exec_en", {63'd0, exec_en}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_halted", {63'd0, halted}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Straight-line program ADD, SUB, MUL.
    mem[0] = ins(0, 1, 2); mem[1] = ins(1, 3, 4); mem[2] = ins(2, 5, 6);
    run(0, 2, 0, 0, 0);
    verify("basic", 0, 2);
    chk("basic_done_cycle", 64'(r_ncyc), 64'd7);

    // LOOP at 5 repeating ADD at 4 four times.
    mem[4] = ins(0, 0, 0); mem[5] = ins(6, 3, 4);
    run(4, 5, 0, 0, 0);
    verify("loop", 4, 5);
    chk("loop_adds", 64'(got_pc_q.size()), 64'd4);
    chk("loop_active_end", {63'd0, dut.loop_active_q}, 64'd0);

    // HALT at 1 long before last_addr.
    mem[10] = ins(3, 0, 0); mem[11] = ins(7, 0, 0); mem[12] = ins(4, 0, 0);
    run(10, 19, 0, 0, 0);
    verify("halt", 10, 19);
    chk("halt_done_cycle", 64'(r_ncyc), 64'd5);
    chk("halt_flag", {63'd0, r_halted}, 64'd1);

    // Hold for 3 cycles during EXEC of instruction 1 (cycles 4..6).
    run(0, 2, 0, 4, 3);
    verify("hold", 0, 2);
    chk("hold_done_cycle", 64'(r_ncyc), 64'd10);
    chk("hold_exec1_cycle", 64'(got_cyc_q.size() > 1 ? got_cyc_q[1] : -1), 64'd7);

    // Reset mid-program, with a start pulse while busy.
    start = 1'b1; start_addr = 10'd0; last_addr = 10'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 10'd5; last_addr = 10'd9;
    @(negedge clk);
    chk("rst_c2_exec_en", {63'd0, exec_en}, 64'd1);
    chk("rst_c2_pc", {54'd0, pc}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; rstn = 1'b0;
    @(negedge clk);
    chk("busy_start_ignored_pc", {54'd0, pc}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_pc", {54'd0, pc}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_exec_en", {63'd0, exec_en}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    chk("rst_mid_halted", {63'd0, halted}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    dn = 0; bz = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bz++;
      @(posedge clk); #1;
    end
    chk("rst_no_done", 64'(dn), 64'd0);
    chk("rst_stays_idle", 64'(bz), 64'd0);

    // Address wrap: 1023 -> 0 -> 1.
    mem[1023] = ins(5, 0, 0); mem[0] = ins(1, 0, 0); mem[1] = ins(2, 0, 0);
    run(1023, 1, 0, 0, 0);
    verify("wrap", 1023, 1);
    chk("wrap_exec_count", 64'(got_pc_q.size()), 64'd3);

    // Random programs with random stalls.
    for (int it = 0; it < 10; it++) begin
      sa  = int'($urandom_range(0, 1023));
      len = int'($urandom_range(1, 12));
      la  = (sa + len - 1) % 1024;
      lpos = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1;
      for (int i = 0; i < len; i++) begin
        op = int'($urandom_range(0, 5));
        if ($urandom_range(0, 9) == 0) op = 7;
        if (i == lpos)
          mem[(sa + i) % 1024] = ins(6, int'($urandom_range(0, 3)),
                                     (sa + int'($urandom_range(0, i))) % 1024);
        else
          mem[(sa + i) % 1024] = ins(op, int'($urandom_range(0, 1023)),
                                     int'($urandom_range(0, 1023)));
      end
      run(sa, la, (it < 5) ? 0 : 30, 0, 0);
      verify("rand", sa, la);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
